// File: rtl/fifo_level.sv
// fifo_level: synchronous FIFO with any DEPTH >= 1. It reports a fill level,
// almost-full/almost-empty flags against thresholds that can change at run
// time, sticky overflow/underflow flags, a synchronous flush, and either a
// show-ahead read port or a registered one.
//
// Ports:
//   clk_i, rst_ni               clock (rising edge), async active-low reset
//   flush_i                     synchronous empty-the-FIFO request
//   wr_en_i, wr_data_i          write request and data
//   rd_en_i                     read request
//   rd_data_o, rd_valid_o       read data; valid marks a delivered word
//   empty_o, full_o, level_o    fill status
//   afull_thr_i, aempty_thr_i   almost-full / almost-empty thresholds
//   almost_full_o/empty_o       level_o >= afull_thr_i / level_o <= aempty_thr_i
//   err_clr_i                   clears the sticky error flags
//   overflow_o, underflow_o     sticky: write dropped / read on empty
module fifo_level #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int REG_OUT = 0,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] level_o,
  input  logic [CNT_W-1:0] afull_thr_i,
  input  logic [CNT_W-1:0] aempty_thr_i,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  input  logic             err_clr_i,
  output logic             overflow_o,
  output logic             underflow_o
);

  // DEPTH=1 keeps a one-bit pointer that never leaves 0.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_level;
  logic             r_ovf;
  logic             r_udf;

  logic             w_empty;
  logic             w_full;
  logic             w_tunnel;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic [CNT_W-1:0] w_level_nxt;
  logic [WIDTH-1:0] w_head;

  // Pointers wrap at DEPTH-1, so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign w_empty = (r_level == {CNT_W{1'b0}});
  assign w_full  = (r_level == CNT_W'(DEPTH));

  // Flush overrides everything, so it also masks every qualifier.
  assign w_tunnel  = wr_en_i & rd_en_i & w_empty & ~flush_i;
  assign w_wr_acc  = wr_en_i & (~w_full | rd_en_i) & ~w_tunnel & ~flush_i;
  assign w_rd_acc  = rd_en_i & ~w_empty & ~flush_i;
  assign w_ovf_set = wr_en_i & w_full & ~rd_en_i & ~flush_i;
  assign w_udf_set = rd_en_i & w_empty & ~wr_en_i & ~flush_i;

  assign w_head = r_mem[r_rd_ptr];

  // Next fill level: only an unpaired write or read changes it.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + CNT_W'(1);
      2'b01:   w_level_nxt = r_level - CNT_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  // Pointers and level, cleared by reset or flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {CNT_W{1'b0}};
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_level <= w_level_nxt;
    end
  end

  // Sticky error flags; a new error in the same cycle beats the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (err_clr_i) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_set) begin
        r_udf <= 1'b1;
      end else if (err_clr_i) begin
        r_udf <= 1'b0;
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] r_rd_data;
      logic             r_rd_valid;

      // Registered read port: one-cycle latency, data holds between reads.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_rd_data  <= {WIDTH{1'b0}};
          r_rd_valid <= 1'b0;
        end else begin
          if (w_rd_acc) begin
            r_rd_data <= w_head;
          end else if (w_tunnel) begin
            r_rd_data <= wr_data_i;
          end
          r_rd_valid <= w_rd_acc | w_tunnel;
        end
      end

      assign rd_data_o  = r_rd_data;
      assign rd_valid_o = r_rd_valid;
    end else begin : g_comb_out
      // Show-ahead: the head is always visible; a tunnel bypasses storage.
      assign rd_data_o  = w_tunnel ? wr_data_i : w_head;
      assign rd_valid_o = w_rd_acc | w_tunnel;
    end
  endgenerate

  assign empty_o        = w_empty;
  assign full_o         = w_full;
  assign level_o        = r_level;
  assign almost_full_o  = (r_level >= afull_thr_i);
  assign almost_empty_o = (r_level <= aempty_thr_i);
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;

endmodule

// File: tb/tb_fifo_level.sv
module tb_fifo_level;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: DEPTH=5, show-ahead read port.
  logic       a_flush = 1'b0, a_wr = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
  logic [7:0] a_wd = 8'h00, a_rdata;
  logic       a_rvalid, a_empty, a_full, a_af, a_ae, a_ovf, a_udf;
  logic [2:0] a_level;
  logic [2:0] a_afthr = 3'd5, a_aethr = 3'd0;

  // Instance B: DEPTH=4, registered read port.
  logic       b_flush = 1'b0, b_wr = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
  logic [7:0] b_wd = 8'h00, b_rdata;
  logic       b_rvalid, b_empty, b_full, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_level;
  logic [2:0] b_afthr = 3'd3, b_aethr = 3'd1;

  fifo_level #(.WIDTH(8), .DEPTH(5), .REG_OUT(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
    .wr_en_i(a_wr), .wr_data_i(a_wd), .rd_en_i(a_rd),
    .rd_data_o(a_rdata), .rd_valid_o(a_rvalid),
    .empty_o(a_empty), .full_o(a_full), .level_o(a_level),
    .afull_thr_i(a_afthr), .aempty_thr_i(a_aethr),
    .almost_full_o(a_af), .almost_empty_o(a_ae),
    .err_clr_i(a_clr), .overflow_o(a_ovf), .underflow_o(a_udf)
  );

  fifo_level #(.WIDTH(8), .DEPTH(4), .REG_OUT(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .wr_en_i(b_wr), .wr_data_i(b_wd), .rd_en_i(b_rd),
    .rd_data_o(b_rdata), .rd_valid_o(b_rvalid),
    .empty_o(b_empty), .full_o(b_full), .level_o(b_level),
    .afull_thr_i(b_afthr), .aempty_thr_i(b_aethr),
    .almost_full_o(b_af), .almost_empty_o(b_ae),
    .err_clr_i(b_clr), .overflow_o(b_ovf), .underflow_o(b_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] b_exp [4];

  initial begin
    b_exp[0] = 8'h82; b_exp[1] = 8'h83; b_exp[2] = 8'h84; b_exp[3] = 8'h99;

    // Reset state
    #2;
    check("a_rst_empty", a_empty, 1);
    check("a_rst_full", a_full, 0);
    check("a_rst_level", a_level, 0);
    check("a_rst_ovf", a_ovf, 0);
    check("a_rst_udf", a_udf, 0);
    check("a_rst_rvalid", a_rvalid, 0);
    check("b_rst_rvalid", b_rvalid, 0);
    check("b_rst_rdata", b_rdata, 0);
    check("b_rst_ae", b_ae, 1);
    check("b_rst_af", b_af, 0);
    #10 rst_n = 1'b1;
    tick();

    // A: fill DEPTH=5
    for (int i = 0; i < 5; i++) begin
      a_wr = 1'b1; a_wd = 8'h11 + 8'(i);
      tick();
    end
    a_wr = 1'b0;
    #1;
    check("a_full", a_full, 1);
    check("a_level5", a_level, 5);
    check("a_af_at5", a_af, 1);
    check("a_ovf_before", a_ovf, 0);

    // A: sixth write dropped
    a_wr = 1'b1; a_wd = 8'h16;
    tick();
    a_wr = 1'b0;
    #1;
    check("a_ovf_set", a_ovf, 1);
    check("a_level_after_ovf", a_level, 5);

    // A: drain in order (show-ahead, valid in the same cycle)
    for (int i = 0; i < 5; i++) begin
      a_rd = 1'b1;
      #1;
      check("a_drain_data", a_rdata, 32'h11 + 32'(i));
      check("a_drain_valid", a_rvalid, 1);
      tick();
    end
    a_rd = 1'b0;
    #1;
    check("a_empty_after_drain", a_empty, 1);
    check("a_level_after_drain", a_level, 0);
    check("a_rvalid_idle", a_rvalid, 0);

    // A: write pointer has wrapped to slot 0
    a_wr = 1'b1; a_wd = 8'h21;
    tick();
    a_wr = 1'b0; a_rd = 1'b1;
    #1;
    check("a_wrap_data", a_rdata, 32'h21);
    tick();
    a_rd = 1'b0;

    // A: tunnel on empty
    a_wr = 1'b1; a_rd = 1'b1; a_wd = 8'hA5;
    #1;
    check("a_tunnel_data", a_rdata, 32'hA5);
    check("a_tunnel_valid", a_rvalid, 1);
    check("a_tunnel_level", a_level, 0);
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    #1;
    check("a_tunnel_level_after", a_level, 0);
    check("a_tunnel_no_udf", a_udf, 0);

    // A: underflow, clear, clear racing a new underflow
    a_rd = 1'b1;
    #1;
    check("a_udf_rvalid", a_rvalid, 0);
    tick();
    a_rd = 1'b0;
    #1;
    check("a_udf_set", a_udf, 1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    #1;
    check("a_udf_cleared", a_udf, 0);
    check("a_ovf_cleared", a_ovf, 0);
    a_clr = 1'b1; a_rd = 1'b1;
    tick();
    a_clr = 1'b0; a_rd = 1'b0;
    #1;
    check("a_udf_set_wins", a_udf, 1);

    // A: flush at level 3 with a concurrent write
    for (int i = 0; i < 3; i++) begin
      a_wr = 1'b1; a_wd = 8'h31 + 8'(i);
      tick();
    end
    a_wr = 1'b0;
    #1;
    check("a_level3", a_level, 3);
    a_flush = 1'b1; a_wr = 1'b1; a_wd = 8'h77;
    tick();
    a_flush = 1'b0; a_wr = 1'b0;
    #1;
    check("a_flush_level", a_level, 0);
    check("a_flush_empty", a_empty, 1);
    check("a_flush_udf_kept", a_udf, 1);
    check("a_flush_ovf_kept", a_ovf, 0);
    a_wr = 1'b1; a_wd = 8'h41;
    tick();
    a_wr = 1'b0;
    #1;
    check("a_post_flush_head", a_rdata, 32'h41);
    check("a_post_flush_level", a_level, 1);

    // B: registered tunnel
    b_wr = 1'b1; b_rd = 1'b1; b_wd = 8'hA5;
    #1;
    check("b_tunnel_valid_early", b_rvalid, 0);
    tick();
    b_wr = 1'b0; b_rd = 1'b0;
    #1;
    check("b_tunnel_data", b_rdata, 32'hA5);
    check("b_tunnel_valid", b_rvalid, 1);
    check("b_tunnel_level", b_level, 0);
    tick();
    check("b_valid_pulse_end", b_rvalid, 0);
    check("b_data_hold", b_rdata, 32'hA5);

    // B: fill with threshold checks (afull=3, aempty=1)
    for (int i = 0; i < 4; i++) begin
      check("b_fill_ae", b_ae, (i <= 1) ? 1 : 0);
      check("b_fill_af", b_af, (i >= 3) ? 1 : 0);
      b_wr = 1'b1; b_wd = 8'h81 + 8'(i);
      tick();
    end
    b_wr = 1'b0;
    #1;
    check("b_full", b_full, 1);
    check("b_af_at4", b_af, 1);
    check("b_ae_at4", b_ae, 0);

    // B: read and write together while full
    b_wr = 1'b1; b_rd = 1'b1; b_wd = 8'h99;
    tick();
    b_wr = 1'b0; b_rd = 1'b0;
    #1;
    check("b_full_rw_data", b_rdata, 32'h81);
    check("b_full_rw_valid", b_rvalid, 1);
    check("b_full_rw_level", b_level, 4);
    check("b_full_rw_no_ovf", b_ovf, 0);

    // B: drain, ending with the word written while full
    for (int i = 0; i < 4; i++) begin
      check("b_drain_af", b_af, ((4 - i) >= 3) ? 1 : 0);
      check("b_drain_ae", b_ae, ((4 - i) <= 1) ? 1 : 0);
      b_rd = 1'b1;
      tick();
      check("b_drain_data", b_rdata, 32'(b_exp[i]));
      check("b_drain_level", b_level, 32'(3 - i));
    end
    b_rd = 1'b0;
    tick();
    check("b_drain_idle_valid", b_rvalid, 0);
    check("b_drain_empty", b_empty, 1);
    check("b_drain_ae0", b_ae, 1);
    check("b_no_udf", b_udf, 0);

    // B: flush with a pending read
    b_wr = 1'b1; b_wd = 8'h55;
    tick();
    b_wd = 8'h56;
    tick();
    b_wr = 1'b0; b_rd = 1'b1; b_flush = 1'b1;
    tick();
    b_rd = 1'b0; b_flush = 1'b0;
    #1;
    check("b_flush_valid", b_rvalid, 0);
    check("b_flush_data_hold", b_rdata, 32'h99);
    check("b_flush_level", b_level, 0);

    // Asynchronous reset between edges, with reads in flight
    b_wr = 1'b1; b_wd = 8'h66;
    a_wr = 1'b1; a_wd = 8'h42;
    tick();
    b_wr = 1'b0; a_wr = 1'b0; b_rd = 1'b1;
    tick();
    b_rd = 1'b0; a_rd = 1'b1;
    #1;
    check("b_pre_rst_valid", b_rvalid, 1);
    check("a_pre_rst_valid", a_rvalid, 1);
    rst_n = 1'b0;
    #1;
    check("a_async_empty", a_empty, 1);
    check("a_async_level", a_level, 0);
    check("a_async_rvalid", a_rvalid, 0);
    check("a_async_udf", a_udf, 0);
    check("b_async_rvalid", b_rvalid, 0);
    check("b_async_rdata", b_rdata, 0);
    check("b_async_level", b_level, 0);
    a_rd = 1'b0;
    #10;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
